mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external SRAM-style bus (cyc/stb/ack) between instruction fetch (IF) and
//  the MEM stage's load/store port.
//  Registers bus commands, waits a variable number of cycles for ack, returns read data, and
//  raises a stall request to the pipeline controller while any request is outstanding.
//  Sits between the IF/MEM stages and the memory subsystem; MEM has fixed priority over IF.
// PARAMETERS
//  WAIT_MAX   255   bus cycles without ack before a transfer is aborted (1..255, 8-bit counter)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  if_req_i      in   1   IF read request; held until if_ready_o
//  if_addr_i     in   32  IF word address
//  if_data_o     out  32  IF read data, valid while if_ready_o=1
//  if_ready_o    out  1   one-cycle completion pulse to IF
//  mem_req_i     in   1   MEM access request; held until mem_ready_o
//  mem_we_i      in   1   1=store, 0=load
//  mem_sel_i     in   4   byte lane enables
//  mem_addr_i    in   32  MEM address
//  mem_wdata_i   in   32  store data
//  mem_rdata_o   out  32  load data, valid while mem_ready_o=1
//  mem_ready_o   out  1   one-cycle completion pulse to MEM
//  bus_cyc_o     out  1   bus cycle active
//  bus_stb_o     out  1   bus strobe (equal to bus_cyc_o)
//  bus_we_o      out  1   bus write enable
//  bus_sel_o     out  4   bus byte lanes
//  bus_addr_o    out  32  bus address
//  bus_wdata_o   out  32  bus write data
//  bus_rdata_i   in   32  bus read data, sampled on ack
//  bus_ack_i     in   1   bus acknowledge
//  bus_err_o     out  1   one-cycle pulse on timeout abort
//  stallreq_o    out  1   stall request to pipeline ctrl (combinational)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (data ports 32'h0); wait counter 0. Async, effective mid-transfer:
//   bus_cyc_o drops immediately; any later ack is ignored.
//  FSM states: IDLE, MEM_BUSY, IF_BUSY. All outputs except stallreq_o are registered.
//  IDLE:
//   - Grant order: mem_req_i (masked while mem_ready_o=1), else if_req_i (masked while if_ready_o=1).
//   - Grant edge: latch addr/we/sel/wdata into bus_*_o; cyc=stb=1; counter<=0; next state MEM_BUSY or IF_BUSY.
//   - IF grants: we=0 and sel=4'b1111.
//   - First bus cycle is the cycle after the request is seen. Ack seen in IDLE is ignored.
//  *_BUSY, bus_ack_i=1:
//   - Capture bus_rdata_i into the granted requester's data output (stores also capture it; MEM ignores).
//   - Pulse that requester's ready for 1 cycle; drop cyc/stb/we; go to IDLE.
//   - Minimum latency: req at cycle 0, ack at cycle 1, ready at cycle 2.
//  *_BUSY, no ack: counter++.
//   - When counter==WAIT_MAX-1 on an edge without ack: abort, same as ack, but data<=32'h0 and bus_err_o pulses.
//   - Ack wins when ack and timeout coincide.
//  Bus outputs are held stable for the whole busy state; requester input changes are ignored until IDLE.
//  Data outputs hold their last value after the ready pulse; they are not cleared.
//  stallreq_o = (mem_req_i & ~mem_ready_o) | (if_req_i & ~if_ready_o).
//  Starvation: IF waits while mem_req_i is asserted in IDLE; the pipeline stall guarantees MEM requests are finite.
// TESTING
//  1 Reset mid-transfer: assert rst while MEM_BUSY -> bus_cyc_o=0 in the same cycle; a later ack produces no ready pulse.
//  2 IF read, ack after 3 cycles, rdata=32'h3C01_0010 -> if_ready_o=1 for one cycle with if_data_o=32'h3C01_0010;
//    stallreq_o=1 until then.
//  3 Simultaneous if_req and mem_req (store, addr 32'h100, sel 4'b0011, data 32'hBEEF) -> MEM served first with bus_we_o=1;
//    IF issued on the cycle after mem_ready_o.
//  4 Zero-wait: ack in the first bus cycle -> ready exactly 2 cycles after req; a held req in the ready cycle is not re-granted.
//  5 No ack, WAIT_MAX=4 -> abort after 4 bus cycles: bus_err_o=1, mem_ready_o=1, mem_rdata_o=0.
//  6 Back-to-back MEM loads with no idle gap between requests -> one bus cycle per request, no lost or duplicated ready pulses.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one SRAM-style cyc/stb/ack bus between instruction fetch (IF) and
//   the MEM stage load/store port. MEM has fixed priority over IF. A granted
//   command is registered onto the bus and held until ack or until WAIT_MAX
//   bus cycles pass without ack, in which case the transfer is aborted with
//   zero data and a one-cycle bus_err_o pulse.
//
// State table
//   IDLE     | no transfer on the bus, arbitrating between MEM and IF
//   MEM_BUSY | MEM command on the bus, waiting for ack or timeout
//   IF_BUSY  | IF fetch on the bus, waiting for ack or timeout
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req_i / if_addr_i     IF read request and word address
//   if_data_o / if_ready_o   IF read data and one-cycle completion pulse
//   mem_req_i, mem_we_i,     MEM request, store flag, byte lanes,
//   mem_sel_i, mem_addr_i,   address and store data
//   mem_wdata_i
//   mem_rdata_o/mem_ready_o  MEM load data and one-cycle completion pulse
//   bus_cyc_o, bus_stb_o,    registered bus command outputs
//   bus_we_o, bus_sel_o,
//   bus_addr_o, bus_wdata_o
//   bus_rdata_i, bus_ack_i   bus read data and acknowledge
//   bus_err_o                one-cycle pulse on timeout abort
//   stallreq_o               combinational stall request to pipeline control
module mem_bus_arbiter #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_BUSY = 2'd1,
        IF_BUSY  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        bus_cyc_q, bus_cyc_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q, bus_err_d;

    // A requester still holds its request during its own ready cycle; masking
    // it there keeps that cycle from re-granting the same transfer.
    logic        mem_go;
    logic        if_go;
    logic        timeout;
    logic        xfer_done;
    logic [31:0] xfer_data;

    assign mem_go    = mem_req_i & ~mem_ready_q;
    assign if_go     = if_req_i & ~if_ready_q;
    assign timeout   = (wait_cnt_q == WAIT_LAST);
    assign xfer_done = bus_ack_i | timeout;
    // Ack wins over a coinciding timeout, so data only zeroes on a true abort.
    assign xfer_data = bus_ack_i ? bus_rdata_i : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'b0000;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Any ack arriving here belongs to nobody and is ignored.
                if (mem_go) begin
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_sel_d   = mem_sel_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    wait_cnt_d  = 8'd0;
                    state_d     = MEM_BUSY;
                end else if (if_go) begin
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'b1111;
                    bus_addr_d  = if_addr_i;
                    wait_cnt_d  = 8'd0;
                    state_d     = IF_BUSY;
                end
            end

            MEM_BUSY, IF_BUSY: begin
                if (xfer_done) begin
                    if (state_q == MEM_BUSY) begin
                        mem_rdata_d = xfer_data;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_data_d  = xfer_data;
                        if_ready_d = 1'b1;
                    end
                    bus_err_d = ~bus_ack_i;
                    bus_cyc_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                bus_cyc_d = 1'b0;
                bus_we_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign if_data_o   = if_data_q;
    assign if_ready_o  = if_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ready_o = mem_ready_q;
    assign bus_cyc_o   = bus_cyc_q;
    assign bus_stb_o   = bus_cyc_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_err_o   = bus_err_q;

    assign stallreq_o  = mem_go | if_go;

endmodule
